// File: rtl/ram_dump_if.sv
// Memory read port and TX FIFO push port seen by the RAM dump engine.
// The master side is the dump engine; the slave side is the RAM/FIFO.
interface ram_dump_if;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        tx_full_i;
  logic        tx_we_o;
  logic [31:0] tx_data_o;

  modport master (
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, tx_we_o, tx_data_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, tx_full_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, tx_we_o, tx_data_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, tx_full_i
  );
endinterface

// File: rtl/ram_dump.sv
// Streams RAM words [BASE_ADDR, end) into the TX FIFO, preceded by a header
// word carrying the end address. One read in flight at most.
//
// state  | meaning
// IDLE   | waiting for start_i, validates end address
// HEADER | push end_q as header word
// REQ    | request read at cur_addr until granted
// WAIT   | wait for read data (abort latched here)
// PUSH   | push captured word, advance cur_addr
// FIN    | done_o pulse, back to IDLE
module ram_dump #(
  parameter logic [31:0] BASE_ADDR = 32'h0010_0000
) (
  input  logic        clk_sys_i,
  input  logic        rst_sys_ni,
  input  logic        start_i,
  input  logic [31:0] end_addr_i,
  input  logic        abort_i,
  ram_dump_if.master  bus,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_PUSH   = 3'd4,
    S_FIN    = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [31:0] end_q, end_d;
  logic [31:0] data_q, data_d;
  logic        abort_q, abort_d;
  logic        err_q, err_d;
  logic [31:0] addr_inc;

  assign addr_inc = cur_addr_q + 32'd4;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q    <= S_IDLE;
      cur_addr_q <= BASE_ADDR;
      end_q      <= '0;
      data_q     <= '0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      end_q      <= end_d;
      data_q     <= data_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    end_d          = end_q;
    data_d         = data_q;
    abort_d        = abort_q;
    err_d          = 1'b0;
    bus.mem_req_o  = 1'b0;
    bus.mem_addr_o = '0;
    bus.tx_we_o    = 1'b0;
    bus.tx_data_o  = '0;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start_i) begin
          if (end_addr_i[1:0] != 2'b00 || end_addr_i < BASE_ADDR) begin
            err_d = 1'b1;
          end else begin
            end_d      = end_addr_i;
            cur_addr_d = BASE_ADDR;
            state_d    = S_HEADER;
          end
        end
      end
      S_HEADER: begin
        bus.tx_data_o = end_q;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!bus.tx_full_i) begin
          bus.tx_we_o = 1'b1;
          state_d     = (cur_addr_q == end_q) ? S_FIN : S_REQ;
        end
      end
      S_REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = cur_addr_q;
        // Once granted the read is in flight, so an abort must wait for rvalid.
        if (bus.mem_gnt_i) begin
          state_d = S_WAIT;
          abort_d = abort_i;
        end else if (abort_i) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          if (abort_q || abort_i) begin
            state_d = S_IDLE;
          end else begin
            data_d  = bus.mem_rdata_i;
            state_d = S_PUSH;
          end
        end else if (abort_i) begin
          abort_d = 1'b1;
        end
      end
      S_PUSH: begin
        bus.tx_data_o = data_q;
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (!bus.tx_full_i) begin
          bus.tx_we_o = 1'b1;
          cur_addr_d  = addr_inc;
          state_d     = (addr_inc == end_q) ? S_FIN : S_REQ;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_we_o = 1'b0;
  assign bus.mem_be_o = 4'hF;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FIN);
  assign err_o        = err_q;

endmodule

// File: tb/tb_ram_dump.sv
// Randomized bench for ram_dump: RAM/FIFO responder, bus monitor and a
// queue-based expectation of the header + word stream for each dump.
module tb_ram_dump;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk_sys;
  logic        rst_sys_n;
  logic        start;
  logic        abort;
  logic [31:0] end_addr;
  logic        busy, done, err;

  ram_dump_if mif();

  ram_dump #(.BASE_ADDR(BASE)) dut (
    .clk_sys_i (clk_sys),
    .rst_sys_ni(rst_sys_n),
    .start_i   (start),
    .end_addr_i(end_addr),
    .abort_i   (abort),
    .bus       (mif),
    .busy_o    (busy),
    .done_o    (done),
    .err_o     (err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  logic [31:0] mem_arr [64];
  logic [31:0] got_q [$];

  int  grant_cnt, done_cnt, err_cnt, req_cnt, busy_cnt;
  int  gnt_delay = 0, rv_delay = 1, full_pct = 0;
  bit  rand_lat = 0, full_on_push = 0;
  int  rv_cnt = 0, gnt_ctr = 0, full_burst = 0;
  logic [31:0] rd_addr;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) >> 2;
    return mem_arr[idx[5:0]];
  endfunction

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // RAM and TX FIFO responder; keeps running through reset so stale rvalids occur.
  initial begin
    mif.mem_gnt_i = 1'b0; mif.mem_rvalid_i = 1'b0;
    mif.mem_rdata_i = '0; mif.tx_full_i = 1'b0;
    forever begin
      @(negedge clk_sys);
      mif.mem_gnt_i    = 1'b0;
      mif.mem_rvalid_i = 1'b0;
      mif.mem_rdata_i  = $urandom;
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mif.mem_rvalid_i = 1'b1;
          mif.mem_rdata_i  = ram_word(rd_addr);
          if (full_on_push) full_burst = 6;
        end
      end else if (mif.mem_req_o) begin
        if (gnt_ctr >= gnt_delay) begin
          mif.mem_gnt_i = 1'b1;
          rd_addr = mif.mem_addr_o;
          rv_cnt  = rv_delay;
          gnt_ctr = 0;
          if (rand_lat) begin
            gnt_delay = $urandom_range(3);
            rv_delay  = $urandom_range(4, 1);
          end
        end else begin
          gnt_ctr++;
        end
      end else begin
        gnt_ctr = 0;
      end
      if (full_burst > 0) begin
        mif.tx_full_i = 1'b1;
        full_burst--;
      end else begin
        mif.tx_full_i = (full_pct > 0) && ($urandom_range(99) < full_pct);
      end
    end
  end

  // Bus monitor, sampled mid-cycle after inputs have settled.
  initial begin
    bit outstanding = 0, prev_req = 0, prev_gnt = 0, prev_done = 0;
    logic [31:0] prev_addr = '0;
    forever begin
      @(negedge clk_sys);
      #2;
      if (mif.tx_we_o) begin
        chk("we_while_full", mif.tx_full_i, 1'b0);
        got_q.push_back(mif.tx_data_o);
      end
      if (mif.mem_req_o) begin
        req_cnt++;
        chk("one_outstanding", outstanding, 1'b0);
        chk("we_be_const", {mif.mem_we_o, mif.mem_be_o}, 5'h0F);
        if (prev_req && !prev_gnt) chk("addr_stable", mif.mem_addr_o, prev_addr);
        if (mif.mem_gnt_i) begin
          chk("rd_addr", mif.mem_addr_o, BASE + 32'(4 * grant_cnt));
          grant_cnt++;
          outstanding = 1;
        end
      end
      if (mif.mem_rvalid_i) outstanding = 0;
      if (prev_done) chk("busy_after_fin", busy, 1'b0);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) busy_cnt++;
      prev_req  = mif.mem_req_o;
      prev_gnt  = mif.mem_gnt_i;
      prev_addr = mif.mem_addr_o;
      prev_done = done;
    end
  end

  task automatic clear_counts();
    got_q.delete();
    grant_cnt = 0; done_cnt = 0; err_cnt = 0; req_cnt = 0; busy_cnt = 0;
  endtask

  // abort_mode: -1 none, 0 abort in REQ before grant, k>0 abort in WAIT of read k.
  task automatic do_dump(input logic [31:0] end_a, input int abort_mode,
                         input int n_words, input bit exp_done, input bit poke_start);
    bit aborted   = 0;
    bit timed_out = 1;
    clear_counts();
    @(negedge clk_sys);
    start = 1'b1; end_addr = end_a;
    @(negedge clk_sys);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      start = 1'b0; abort = 1'b0;
      if (!busy) begin
        timed_out = 0;
        break;
      end
      if (!aborted && abort_mode == 0 && mif.mem_req_o && grant_cnt == 0) begin
        abort = 1'b1; aborted = 1;
      end
      if (!aborted && abort_mode > 0 && grant_cnt == abort_mode) begin
        abort = 1'b1; aborted = 1;
      end
      if (poke_start && $urandom_range(3) == 0) begin
        start = 1'b1; end_addr = $urandom;
      end
      @(negedge clk_sys);
    end
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("timeout", timed_out, 1'b0);
    chk("push_count", got_q.size(), n_words + 1);
    if (got_q.size() == n_words + 1) begin
      chk("header", got_q[0], end_a);
      for (int i = 0; i < n_words; i++) chk("word", got_q[i + 1], mem_arr[i]);
    end
    chk("done_count", done_cnt, exp_done);
    chk("err_count", err_cnt, 0);
  endtask

  task automatic bad_start(input logic [31:0] end_a);
    clear_counts();
    @(negedge clk_sys);
    start = 1'b1; end_addr = end_a;
    @(negedge clk_sys);
    start = 1'b0;
    chk("err_pulse", err, 1'b1);
    repeat (5) @(negedge clk_sys);
    chk("err_once", err_cnt, 1);
    chk("err_no_push", got_q.size(), 0);
    chk("err_no_req", req_cnt, 0);
    chk("err_no_busy", busy_cnt, 0);
  endtask

  initial begin
    int n;
    int req_at_rst;
    for (int i = 0; i < 64; i++) mem_arr[i] = $urandom;
    rst_sys_n = 1'b0; start = 1'b0; abort = 1'b0; end_addr = '0;
    repeat (3) @(negedge clk_sys);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", mif.mem_req_o, 1'b0);
    chk("rst_addr", mif.mem_addr_o, 32'h0);
    chk("rst_tx_we", mif.tx_we_o, 1'b0);
    chk("rst_tx_data", mif.tx_data_o, 32'h0);
    chk("rst_we_be", {mif.mem_we_o, mif.mem_be_o}, 5'h0F);
    rst_sys_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    // Three words, immediate grant, rvalid one cycle later.
    gnt_delay = 0; rv_delay = 1;
    do_dump(BASE + 32'd12, -1, 3, 1, 0);

    // Empty range: header only, never a request.
    do_dump(BASE, -1, 0, 1, 0);
    chk("empty_no_req", req_cnt, 0);

    bad_start(BASE + 32'd2);
    bad_start(BASE - 32'd4);

    // FIFO full for 5 cycles on every push, slow grants.
    gnt_delay = 3; rv_delay = 1; full_on_push = 1;
    do_dump(BASE + 32'd16, -1, 4, 1, 0);
    full_on_push = 0;

    // Abort while waiting for data, then a normal dump.
    gnt_delay = 0; rv_delay = 4;
    do_dump(BASE + 32'd16, 2, 1, 0, 0);
    do_dump(BASE + 32'd8, -1, 2, 1, 0);

    // Abort in REQ before grant.
    gnt_delay = 3; rv_delay = 1;
    do_dump(BASE + 32'd16, 0, 0, 0, 0);
    chk("abort_req_no_gnt", grant_cnt, 0);

    // Randomized dumps with random latencies, FIFO backpressure, ignored starts.
    rand_lat = 1; full_pct = 30;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(12);
      do_dump(BASE + 32'(4 * n), -1, n, 1, 1);
    end
    rand_lat = 0; full_pct = 0;

    // Reset in the middle of a read; the late rvalid must be ignored.
    gnt_delay = 0; rv_delay = 4;
    repeat (6) @(negedge clk_sys);
    clear_counts();
    start = 1'b1; end_addr = BASE + 32'd16;
    @(negedge clk_sys);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (grant_cnt == 1) break;
      @(negedge clk_sys);
    end
    rst_sys_n = 1'b0;
    #1;
    req_at_rst = req_cnt;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_err", err, 1'b0);
    chk("midrst_req", mif.mem_req_o, 1'b0);
    chk("midrst_addr", mif.mem_addr_o, 32'h0);
    chk("midrst_tx_we", mif.tx_we_o, 1'b0);
    chk("midrst_tx_data", mif.tx_data_o, 32'h0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    repeat (10) @(negedge clk_sys);
    chk("midrst_pushes", got_q.size(), 1);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_no_req", req_cnt, req_at_rst);
    chk("midrst_idle", busy, 1'b0);

    // Normal operation after the reset.
    do_dump(BASE + 32'd4, -1, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_dump.md
RAM_DUMP -- requirements
Module: ram_dump

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0010_0000, meaning the first RAM word address read; it is word-aligned.
REQ-002 SHALL have the port clk_sys_i  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have the port rst_sys_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have the port start_i  input  1  single-cycle request to begin a dump.
REQ-005 SHALL have the port end_addr_i  input  32  exclusive end byte address, sampled on start.
REQ-006 SHALL have the port abort_i  input  1  terminate the dump early.
REQ-007 SHALL have the port mem_req_o  output  1  RAM read request.
REQ-008 SHALL have the port mem_gnt_i  input  1  RAM grant for mem_req_o.
REQ-009 SHALL have the port mem_we_o  output  1  RAM write enable, constant 0.
REQ-010 SHALL have the port mem_be_o  output  4  byte enable, constant 4'hF.
REQ-011 SHALL have the port mem_addr_o  output  32  RAM word address.
REQ-012 SHALL have the port mem_rvalid_i  input  1  read data valid.
REQ-013 SHALL have the port mem_rdata_i  input  32  read data.
REQ-014 SHALL have the port tx_full_i  input  1  TX FIFO full.
REQ-015 SHALL have the port tx_we_o  output  1  TX FIFO push strobe.
REQ-016 SHALL have the port tx_data_o  output  32  word pushed into the TX FIFO.
REQ-017 SHALL have the port busy_o  output  1  high from the cycle after an accepted start until return to IDLE.
REQ-018 SHALL have the port done_o  output  1  one-cycle pulse on normal completion.
REQ-019 SHALL have the port err_o  output  1  one-cycle pulse on a rejected start.

Function
REQ-020 SHALL implement the states IDLE, HEADER, REQ, WAIT, PUSH and FIN, encoded in 3 bits.
REQ-021 In IDLE, start_i SHALL be checked; a start with end_addr_i[1:0]!=0 or end_addr_i<BASE_ADDR SHALL pulse err_o the next cycle and stay in IDLE.
REQ-022 On a valid start, the block SHALL latch end_addr_i into end_q, load cur_addr=BASE_ADDR, and go to HEADER.
REQ-023 HEADER SHALL place end_q on tx_data_o and assert tx_we_o for exactly one cycle when tx_full_i=0, else wait; this header word matches the loader's first-word format.
REQ-024 After the header push, the block SHALL go to FIN if cur_addr==end_q, else to REQ.
REQ-025 REQ SHALL hold mem_req_o=1 and mem_addr_o=cur_addr stable until a cycle with mem_gnt_i=1, then deassert mem_req_o the next cycle and go to WAIT.
REQ-026 WAIT SHALL capture mem_rdata_i into data_q in the cycle mem_rvalid_i=1 and go to PUSH; rvalid in the grant cycle is not expected, and rvalid outside WAIT SHALL be ignored.
REQ-027 PUSH SHALL drive tx_data_o=data_q with a one-cycle tx_we_o when tx_full_i=0, then set cur_addr=cur_addr+4 (32-bit modulo) and go to FIN if the new cur_addr==end_q, else to REQ.
REQ-028 FIN SHALL pulse done_o for one cycle and return to IDLE; busy_o SHALL be low in the cycle after FIN.
REQ-029 tx_we_o SHALL never be asserted while tx_full_i=1, and every word SHALL be pushed exactly once in address order.
REQ-030 Exactly one memory read SHALL be outstanding at most; mem_req_o SHALL never assert outside REQ.
REQ-031 abort_i in HEADER, REQ (before grant) or PUSH SHALL return to IDLE next cycle with no further push, request, or done_o.
REQ-032 abort_i in WAIT, or in REQ in the grant cycle, SHALL be latched; the block SHALL wait for mem_rvalid_i, discard the data, and return to IDLE without done_o.
REQ-033 start_i while busy_o=1 SHALL be ignored, with no err_o.
REQ-034 Words transferred SHALL equal (end_q-BASE_ADDR)/4; the header is always sent for a valid start.

Reset
REQ-035 Asserting rst_sys_ni low SHALL immediately force state=IDLE and set mem_req_o=0, mem_addr_o=0, tx_we_o=0, tx_data_o=0, busy_o=0, done_o=0, err_o=0, cur_addr=BASE_ADDR, end_q=0, data_q=0 and the abort latch to 0.
REQ-036 Reset mid-dump SHALL abandon the transfer, and any later mem_rvalid_i SHALL be ignored.
REQ-037 mem_we_o=0 and mem_be_o=4'hF SHALL hold in reset and in every state.

Verification
REQ-038 Start with end_addr_i=BASE_ADDR+12, RAM words A,B,C, 1-cycle grant, rvalid 1 cycle after grant -> TX sequence BASE_ADDR+12, A, B, C, then done_o one pulse and busy_o low next cycle.
REQ-039 Start with end_addr_i=BASE_ADDR -> only the header pushed, done_o pulse, mem_req_o never asserted.
REQ-040 Start with end_addr_i=BASE_ADDR+2 or BASE_ADDR-4 -> err_o one pulse, no push, no request, busy_o stays 0.
REQ-041 tx_full_i held high 5 cycles during PUSH, and mem_gnt_i delayed 3 cycles -> no tx_we_o while full, mem_addr_o stable during the request, data order preserved.
REQ-042 abort_i during WAIT with rvalid 4 cycles later -> no push of that word, return to IDLE after rvalid, no done_o; a new start is then accepted normally.
REQ-043 rst_sys_ni pulsed low mid-dump -> all outputs are at reset values immediately; a stale rvalid afterwards causes no push.
